// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit: predictor modes,
// 2-bit saturating counter encoding and its update functions.
package bpu_pkg;

  typedef enum logic [1:0] {
    BPU_STATIC  = 2'd0,
    BPU_BIMODAL = 2'd1,
    BPU_GSHARE  = 2'd2
  } bpu_mode_e;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t SNT = 2'b00;
  localparam ctr2_t WNT = 2'b01;
  localparam ctr2_t WT  = 2'b10;
  localparam ctr2_t ST  = 2'b11;

  function automatic ctr2_t ctr_inc(input ctr2_t c);
    return (c == ST) ? ST : ctr2_t'(c + 2'd1);
  endfunction

  function automatic ctr2_t ctr_dec(input ctr2_t c);
    return (c == SNT) ? SNT : ctr2_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: combinational lookup by fetch PC,
// single write port from the execute stage; only valid bits are reset.
module bpu_btb #(
  parameter int unsigned BTB_ENTRIES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] rd_pc_i,
  output logic        rd_hit_o,
  output logic [31:0] rd_target_o,
  output logic        rd_is_jmp_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_pc_i,
  input  logic [31:0] wr_target_i,
  input  logic        wr_is_jmp_i
);

  localparam int unsigned IB = $clog2(BTB_ENTRIES);
  localparam int unsigned TW = 30 - IB;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [BTB_ENTRIES-1:0] is_jmp_q;
  logic [TW-1:0]          tag_q    [BTB_ENTRIES];
  logic [29:0]            target_q [BTB_ENTRIES];

  logic [IB-1:0] rd_idx;
  logic [IB-1:0] wr_idx;
  logic          unused_low_bits;

  assign rd_idx = rd_pc_i[IB+1:2];
  assign wr_idx = wr_pc_i[IB+1:2];
  assign unused_low_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0], wr_target_i[1:0]};

  always_comb begin
    rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc_i[31:IB+2]);
    rd_target_o = {target_q[rd_idx], 2'b00};
    rd_is_jmp_o = is_jmp_q[rd_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx]    <= wr_pc_i[31:IB+2];
      target_q[wr_idx] <= wr_target_i[31:2];
      is_jmp_q[wr_idx] <= wr_is_jmp_i;
    end
  end

endmodule

// File: rtl/bpu_gshare.sv
// Branch prediction unit: BTB lookup plus 2-bit counter table (static,
// bimodal or gshare), execute-stage mispredict detection and perf counters.
module bpu_gshare
  import bpu_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 64,
  parameter int unsigned BHT_ENTRIES = 256,
  parameter int unsigned GHR_BITS    = 8,
  parameter int unsigned MODE        = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] fetch_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic        ex_is_br_i,
  input  logic        ex_is_jmp_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        flush_o,
  output logic [31:0] nxt_pc_o,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int unsigned IH     = $clog2(BHT_ENTRIES);
  localparam bpu_mode_e   MODE_E = bpu_mode_e'(MODE[1:0]);

  ctr2_t               ctr_q [BHT_ENTRIES];
  logic [GHR_BITS-1:0] ghr_q;
  logic [31:0]         br_cnt_q;
  logic [31:0]         mis_cnt_q;

  logic          btb_hit;
  logic          btb_is_jmp;
  logic [31:0]   btb_target;
  logic [IH-1:0] hist;
  logic [IH-1:0] fetch_idx;
  logic [IH-1:0] ex_idx;
  logic          ex_ctrl;
  logic          mis;

  bpu_btb #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rd_pc_i     (fetch_pc_i),
    .rd_hit_o    (btb_hit),
    .rd_target_o (btb_target),
    .rd_is_jmp_o (btb_is_jmp),
    .wr_en_i     (ex_ctrl & ex_taken_i),
    .wr_pc_i     (ex_pc_i),
    .wr_target_i (ex_target_i),
    .wr_is_jmp_i (ex_is_jmp_i)
  );

  always_comb begin
    hist      = (MODE_E == BPU_GSHARE) ? IH'(ghr_q) : '0;
    fetch_idx = fetch_pc_i[IH+1:2] ^ hist;
    ex_idx    = ex_pc_i[IH+1:2] ^ hist;
    ex_ctrl   = ex_valid_i & (ex_is_br_i | ex_is_jmp_i);
    mis       = ex_ctrl & ((ex_taken_i != ex_pred_taken_i) |
                           (ex_taken_i & (ex_target_i != ex_pred_target_i)));

    pred_taken_o  = btb_hit & (btb_is_jmp | ((MODE_E != BPU_STATIC) & ctr_q[fetch_idx][1]));
    pred_target_o = btb_hit ? btb_target : fetch_pc_i + 32'd4;
    flush_o       = mis;

    // A resolved mispredict in S2 wins over whatever S0 predicts this cycle.
    if (mis) begin
      nxt_pc_o = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    end else if (pred_taken_o) begin
      nxt_pc_o = pred_target_o;
    end else begin
      nxt_pc_o = fetch_pc_i + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        ctr_q[i] <= WNT;
      end
      ghr_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (ex_ctrl) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (mis) begin
        mis_cnt_q <= mis_cnt_q + 32'd1;
      end
      if (ex_is_br_i && (MODE_E != BPU_STATIC)) begin
        ctr_q[ex_idx] <= ex_taken_i ? ctr_inc(ctr_q[ex_idx]) : ctr_dec(ctr_q[ex_idx]);
        ghr_q         <= GHR_BITS'({ghr_q, ex_taken_i});
      end
    end
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mis_cnt_q;

endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench: a bimodal and a 2-bit-history gshare instance share
// stimulus; each is compared against an array-based predictor model.
module tb_bpu_gshare;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        ex_valid, ex_is_br, ex_is_jmp, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;

  logic        pt  [2];
  logic [31:0] ptg [2];
  logic        fl  [2];
  logic [31:0] nx  [2];
  logic [31:0] bc  [2];
  logic [31:0] mc  [2];

  always #5 clk = ~clk;

  bpu_gshare #(.BTB_ENTRIES(64), .BHT_ENTRIES(256), .GHR_BITS(8), .MODE(1)) u_bim (
    .clk_i(clk), .rst_ni(rst_n), .fetch_pc_i(fetch_pc),
    .pred_taken_o(pt[0]), .pred_target_o(ptg[0]),
    .ex_valid_i(ex_valid), .ex_is_br_i(ex_is_br), .ex_is_jmp_i(ex_is_jmp),
    .ex_pc_i(ex_pc), .ex_taken_i(ex_taken), .ex_target_i(ex_target),
    .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target),
    .flush_o(fl[0]), .nxt_pc_o(nx[0]), .br_cnt_o(bc[0]), .mispred_cnt_o(mc[0])
  );

  bpu_gshare #(.BTB_ENTRIES(64), .BHT_ENTRIES(256), .GHR_BITS(2), .MODE(2)) u_gsh (
    .clk_i(clk), .rst_ni(rst_n), .fetch_pc_i(fetch_pc),
    .pred_taken_o(pt[1]), .pred_target_o(ptg[1]),
    .ex_valid_i(ex_valid), .ex_is_br_i(ex_is_br), .ex_is_jmp_i(ex_is_jmp),
    .ex_pc_i(ex_pc), .ex_taken_i(ex_taken), .ex_target_i(ex_target),
    .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target),
    .flush_o(fl[1]), .nxt_pc_o(nx[1]), .br_cnt_o(bc[1]), .mispred_cnt_o(mc[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference state: BTB keyed by pc/4 mod 64 holding the full upper PC,
  // counters as plain integers 0..3, history as an integer mod 2^bits.
  bit          mv   [2][64];
  int unsigned mtag [2][64];
  int unsigned mtgt [2][64];
  bit          mj   [2][64];
  int          mctr [2][256];
  int unsigned mghr [2];
  int unsigned mbr  [2];
  int unsigned mmis [2];
  int          mmode[2];
  int          mgb  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned bht_idx(input int k, input int unsigned pc, input int unsigned g);
    if (mmode[k] == 2) return ((pc >> 2) ^ g) % 256;
    return (pc >> 2) % 256;
  endfunction

  task automatic model_pred(input int k, input int unsigned pc, output bit tk, output int unsigned tg);
    int unsigned b = (pc >> 2) % 64;
    bit hit = mv[k][b] && (mtag[k][b] == (pc >> 8));
    tk = hit && (mj[k][b] || (mmode[k] != 0 && mctr[k][bht_idx(k, pc, mghr[k])] >= 2));
    tg = hit ? mtgt[k][b] : pc + 4;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) mv[k][i] = 1'b0;
      for (int i = 0; i < 256; i++) mctr[k][i] = 1;
      mghr[k] = 0;
      mbr[k]  = 0;
      mmis[k] = 0;
    end
  endtask

  task automatic step(input int unsigned fpc, input bit v, input bit br, input bit jmp,
                      input int unsigned epc, input bit t, input int unsigned etgt,
                      input bit ep, input int unsigned eptg);
    bit mis;
    bit tk;
    int unsigned tg, exp_nx, bi, hi;
    @(negedge clk);
    fetch_pc = fpc; ex_valid = v; ex_is_br = br; ex_is_jmp = jmp; ex_pc = epc;
    ex_taken = t; ex_target = etgt; ex_pred_taken = ep; ex_pred_target = eptg;
    #1;
    mis = v && (br || jmp) && (t != ep || (t && etgt != eptg));
    for (int k = 0; k < 2; k++) begin
      model_pred(k, fpc, tk, tg);
      if (mis) exp_nx = t ? etgt : epc + 4;
      else     exp_nx = tk ? tg : fpc + 4;
      chk($sformatf("i%0d pred_taken pc=%h", k, fpc), 32'(pt[k]), 32'(tk));
      chk($sformatf("i%0d pred_target pc=%h", k, fpc), ptg[k], tg);
      chk($sformatf("i%0d flush", k), 32'(fl[k]), 32'(mis));
      chk($sformatf("i%0d nxt_pc", k), nx[k], exp_nx);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (v && (br || jmp)) begin
        if (t) begin
          bi = (epc >> 2) % 64;
          mv[k][bi] = 1'b1; mtag[k][bi] = epc >> 8; mtgt[k][bi] = etgt & ~32'd3; mj[k][bi] = jmp;
        end
        if (br && mmode[k] != 0) begin
          hi = bht_idx(k, epc, mghr[k]);
          mctr[k][hi] = t ? ((mctr[k][hi] == 3) ? 3 : mctr[k][hi] + 1)
                          : ((mctr[k][hi] == 0) ? 0 : mctr[k][hi] - 1);
          mghr[k] = ((mghr[k] << 1) | 32'(t)) % (32'd1 << mgb[k]);
        end
        mbr[k]++;
        if (mis) mmis[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d br_cnt", k), bc[k], mbr[k]);
      chk($sformatf("i%0d mispred_cnt", k), mc[k], mmis[k]);
    end
  endtask

  task automatic fetch(input int unsigned pc);
    step(pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve_with_pred(input int k, input int unsigned fpc, input bit br, input bit jmp,
                                   input int unsigned epc, input bit t, input int unsigned etgt);
    bit tk;
    int unsigned tg;
    model_pred(k, epc, tk, tg);
    step(fpc, 1, br, jmp, epc, t, etgt, tk, tg);
  endtask

  initial begin
    int unsigned saved;
    mmode[0] = 1; mgb[0] = 8;
    mmode[1] = 2; mgb[1] = 2;
    model_reset();
    rst_n = 1'b0;
    fetch_pc = 32'h100; ex_valid = 0; ex_is_br = 0; ex_is_jmp = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d reset pred_taken", k), 32'(pt[k]), 32'd0);
      chk($sformatf("i%0d reset nxt_pc", k), nx[k], 32'h104);
      chk($sformatf("i%0d reset br_cnt", k), bc[k], 32'd0);
      chk($sformatf("i%0d reset mispred_cnt", k), mc[k], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    fetch(32'h100);
    // Branch 0x200 -> 0x180 taken, predicted not-taken
    step(32'h104, 1, 1, 0, 32'h200, 1, 32'h180, 0, 32'h204);
    chk("mispredict count after first branch", mc[0], 32'd1);
    fetch(32'h200);
    chk("bimodal predicts taken", 32'(pt[0]), 32'd1);
    chk("bimodal target", ptg[0], 32'h180);

    // Saturation: five more taken, then one not-taken
    for (int i = 0; i < 5; i++) resolve_with_pred(0, 32'h104, 1, 0, 32'h200, 1, 32'h180);
    resolve_with_pred(0, 32'h104, 1, 0, 32'h200, 0, 32'h180);
    fetch(32'h200);
    chk("saturated then decremented stays taken", 32'(pt[0]), 32'd1);

    // Aliasing: JAL 0x300 -> 0x40, then same index different tag
    step(32'h104, 1, 0, 1, 32'h300, 1, 32'h40, 0, 32'h304);
    fetch(32'h300);
    chk("jal hit target", ptg[0], 32'h40);
    fetch(32'h400);
    chk("alias miss nxt_pc", nx[0], 32'h404);

    // Same-cycle update and fetch of the same entry reads the old contents
    step(32'h600, 1, 1, 0, 32'h600, 1, 32'h700, 0, 32'h604);
    fetch(32'h600);
    chk("post-update fetch hits", ptg[0], 32'h700);

    // Invalid S2 slot changes nothing
    step(32'h800, 0, 1, 0, 32'h800, 1, 32'h900, 0, 32'h804);
    fetch(32'h800);
    chk("invalid slot not written", 32'(pt[0]), 32'd0);

    // Gshare alternating pattern converges
    saved = 0;
    for (int i = 0; i < 16; i++) begin
      resolve_with_pred(1, 32'h500, 1, 0, 32'h500, (i % 2) == 0, 32'h580);
      if (i == 7) saved = mmis[1];
    end
    chk("gshare no mispredicts after warm-up", mc[1], saved);

    // Mid-sequence reset clears the BTB
    step(32'h104, 1, 0, 1, 32'h200, 1, 32'h180, 0, 32'h204);
    fetch(32'h200);
    chk("jump entry present before reset", 32'(pt[0]), 32'd1);
    @(negedge clk);
    ex_valid = 0; fetch_pc = 32'h200;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d async reset pred_taken", k), 32'(pt[k]), 32'd0);
      chk($sformatf("i%0d async reset nxt_pc", k), nx[k], 32'h204);
      chk($sformatf("i%0d async reset br_cnt", k), bc[k], 32'd0);
      chk($sformatf("i%0d async reset mispred_cnt", k), mc[k], 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h200);

    // Randomised traffic over a few tags sharing BTB indices
    for (int i = 0; i < 400; i++) begin
      int unsigned fpc, epc, tgt, kind;
      bit t, v;
      fpc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
      epc  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
      tgt  = ($urandom_range(0, 1) == 0) ? 32'h1000 + (epc & 32'hfc) : ($urandom & ~32'd3);
      kind = $urandom_range(0, 3);
      v    = ($urandom_range(0, 9) != 0);
      t    = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      if (kind == 0) fetch(fpc);
      else if ($urandom_range(0, 1) == 0)
        resolve_with_pred($urandom_range(0, 1), fpc, kind != 2, kind == 2, epc, t, tgt);
      else
        step(fpc, v, kind != 2, kind == 2, epc, t, tgt, 1'($urandom_range(0, 1)), $urandom & ~32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
